// File: rtl/proc_pkg.sv
// Shared fetch-side definitions: sequencer states and instruction memory
// constants used by the fetch sequencer, instruction memory and top level.
package proc_pkg;

    typedef enum logic [1:0] {
        FETCH,
        HALT,
        FAULT
    } fetch_state_e;

    localparam int INSTR_BYTES = 4;

    localparam int          DEFAULT_IMEM_BYTES = 76;
    localparam logic [63:0] DEFAULT_RESET_PC   = 64'h0;

endpackage

// File: rtl/fetch_out_stage.sv
// Single-entry valid/ready register holding one fetched word and its address.
// Flush wins over load; an unloaded transfer empties the entry.
module fetch_out_stage #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               flush,
    input  logic               ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc
);

    logic               vld_p1;
    logic [INSTR_W-1:0] instr_p1;
    logic [ADDR_W-1:0]  pc_p1;

    // Stage p1: registered word toward decode
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1   <= 1'b0;
            instr_p1 <= '0;
            pc_p1    <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (load) begin
            vld_p1   <= 1'b1;
            instr_p1 <= instr_in;
            pc_p1    <= pc_in;
        end else if (vld_p1 && ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign valid = vld_p1;
    assign instr = instr_p1;
    assign pc    = pc_p1;

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, addresses the combinational imem,
// and feeds one registered word per cycle to decode with redirect/halt/fault.
module imem_fetch_sequencer
    import proc_pkg::*;
#(
    parameter int                ADDR_W     = 64,
    parameter int                INSTR_W    = 32,
    parameter int                IMEM_BYTES = DEFAULT_IMEM_BYTES,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                CNT_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               stall,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted,
    output logic               misalign_fault,
    output logic [CNT_W-1:0]   fetch_count
);

    fetch_state_e      state_p0, state_next;
    logic [ADDR_W-1:0] pc_p0, pc_next;
    logic [CNT_W-1:0]  cnt_p0;

    logic [ADDR_W:0]   pc_plus4;
    logic              in_range;
    logic              load;
    logic              flush;
    logic              xfer;

    // One extra bit so that pc+4 wrapping past 2^ADDR_W reads as out of range.
    assign pc_plus4 = {1'b0, pc_p0} + (ADDR_W+1)'(INSTR_BYTES);
    assign in_range = pc_plus4 <= (ADDR_W+1)'(IMEM_BYTES);

    assign xfer  = out_valid && out_ready;
    assign flush = redirect_valid && (state_p0 != FAULT);
    assign load  = (state_p0 == FETCH) && (!out_valid || out_ready) && !stall
                   && !redirect_valid && in_range;

    always_comb begin
        state_next = state_p0;
        pc_next    = pc_p0;
        case (state_p0)
            FETCH, HALT: begin
                if (redirect_valid) begin
                    if (redirect_target[1:0] == 2'b00) begin
                        pc_next    = redirect_target;
                        state_next = FETCH;
                    end else begin
                        state_next = FAULT;
                    end
                end else if (state_p0 == FETCH) begin
                    if (load) begin
                        pc_next = pc_plus4[ADDR_W-1:0];
                    end else if (!in_range) begin
                        state_next = HALT;
                    end
                end
            end
            default: ;
        endcase
    end

    // Stage p0: PC, sequencer state and handshake counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_p0 <= FETCH;
            pc_p0    <= RESET_PC;
            cnt_p0   <= '0;
        end else begin
            state_p0 <= state_next;
            pc_p0    <= pc_next;
            if (xfer) begin
                cnt_p0 <= cnt_p0 + CNT_W'(1);
            end
        end
    end

    fetch_out_stage #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_out_stage (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .flush    (flush),
        .ready    (out_ready),
        .instr_in (imem_instr),
        .pc_in    (pc_p0),
        .valid    (out_valid),
        .instr    (out_instr),
        .pc       (out_pc)
    );

    assign imem_addr      = pc_p0;
    assign halted         = (state_p0 == HALT);
    assign misalign_fault = (state_p0 == FAULT);
    assign fetch_count    = cnt_p0;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: directed stimulus, a behavioural fetch model
// compared every cycle, and literal expectations for the test-plan scenarios.
module tb_imem_fetch_sequencer;

    localparam int NWORDS = 19;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        stall;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        halted;
    logic        misalign_fault;
    logic [31:0] fetch_count;

    logic [31:0] rom [NWORDS];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_fetch_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall           (stall),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .halted          (halted),
        .misalign_fault  (misalign_fault),
        .fetch_count     (fetch_count)
    );

    always_comb begin
        imem_instr = 32'hdeadbeef;
        if (imem_addr < 64'd76) imem_instr = rom[int'(imem_addr >> 2)];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Behavioural model: mode 0=fetching, 1=halted, 2=faulted
    logic        model_ok = 1'b0;
    int          m_mode   = 0;
    logic [63:0] m_pc     = '0;
    logic        m_vld    = 1'b0;
    logic [31:0] m_instr  = '0;
    logic [63:0] m_opc    = '0;
    logic [31:0] m_cnt    = '0;

    always @(posedge clk) begin : model
        int          n_mode;
        logic [63:0] n_pc;
        logic        n_vld;
        logic [31:0] n_instr;
        logic [63:0] n_opc;
        logic [31:0] n_cnt;
        logic        took;
        logic        fits;
        n_mode = m_mode; n_pc = m_pc; n_vld = m_vld;
        n_instr = m_instr; n_opc = m_opc; n_cnt = m_cnt;
        if (!reset) begin
            n_mode = 0; n_pc = '0; n_vld = 1'b0; n_instr = '0; n_opc = '0; n_cnt = '0;
            model_ok <= 1'b1;
        end else begin
            took = m_vld && out_ready;
            fits = (m_pc <= 64'd72);
            if (took) n_cnt = m_cnt + 1;
            if (m_mode == 2) begin
                n_vld = 1'b0;
            end else if (redirect_valid) begin
                n_vld = 1'b0;
                if (redirect_target % 4 == 0) begin
                    n_pc = redirect_target;
                    n_mode = 0;
                end else begin
                    n_mode = 2;
                end
            end else if (m_mode == 0 && fits && !stall && (!m_vld || out_ready)) begin
                n_vld = 1'b1;
                n_instr = rom[int'(m_pc / 4)];
                n_opc = m_pc;
                n_pc = m_pc + 4;
            end else begin
                if (m_mode == 0 && !fits) n_mode = 1;
                if (took) n_vld = 1'b0;
            end
        end
        m_mode <= n_mode; m_pc <= n_pc; m_vld <= n_vld;
        m_instr <= n_instr; m_opc <= n_opc; m_cnt <= n_cnt;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("m_imem_addr", imem_addr, m_pc);
            chk("m_out_valid", 64'(out_valid), 64'(m_vld));
            chk("m_out_pc", out_pc, m_opc);
            chk("m_out_instr", 64'(out_instr), 64'(m_instr));
            chk("m_halted", 64'(halted), 64'(m_mode == 1));
            chk("m_misalign", 64'(misalign_fault), 64'(m_mode == 2));
            chk("m_fetch_count", 64'(fetch_count), 64'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rom[0]  = 32'h00a00f93; rom[1]  = 32'h00000f13; rom[2]  = 32'h001e8f13;
        rom[3]  = 32'h00053483; rom[4]  = 32'h00148493; rom[5]  = 32'h00940433;
        rom[6]  = 32'hfe9ff06f; rom[7]  = 32'h00000013; rom[8]  = 32'h01174663;
        rom[9]  = 32'h00100293; rom[10] = 32'h00528333; rom[11] = 32'h406283b3;
        rom[12] = 32'h0062f433; rom[13] = 32'h0062e4b3; rom[14] = 32'h00629533;
        rom[15] = 32'h0062d5b3; rom[16] = 32'h00c0006f; rom[17] = 32'h00000013;
        rom[18] = 32'hfbfecee3;

        reset = 1'b0; out_ready = 1'b1; stall = 1'b0;
        redirect_valid = 1'b0; redirect_target = '0;
        step(); step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);
        chk("rst_count", 64'(fetch_count), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_addr", imem_addr, 64'h0);

        reset = 1'b1;
        step();
        chk("c1_valid", 64'(out_valid), 64'd1);
        chk("c1_pc", out_pc, 64'h0);
        chk("c1_instr", 64'(out_instr), 64'h00a00f93);
        step();
        chk("c2_pc", out_pc, 64'h4);
        chk("c2_instr", 64'(out_instr), 64'h00000f13);
        step();
        chk("c3_count", 64'(fetch_count), 64'd2);
        chk("c3_instr", 64'(out_instr), 64'h001e8f13);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_pc", out_pc, 64'h8);
            chk("bp_addr", imem_addr, 64'hc);
        end
        out_ready = 1'b1;
        step();
        chk("bp_next_pc", out_pc, 64'hc);
        chk("bp_next_instr", 64'(out_instr), 64'h00053483);
        step();
        chk("w10_pc", out_pc, 64'h10);

        out_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 64'h20;
        step();
        chk("rd_flush", 64'(out_valid), 64'd0);
        redirect_valid = 1'b0;
        step();
        chk("rd_pc", out_pc, 64'h20);
        chk("rd_instr", 64'(out_instr), 64'h01174663);
        chk("rd_count", 64'(fetch_count), 64'd4);

        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid && out_pc == 64'h48) break;
        end
        chk("end_pc", out_pc, 64'h48);
        chk("end_instr", 64'(out_instr), 64'hfbfecee3);
        step();
        chk("end_halted", 64'(halted), 64'd1);
        chk("end_valid", 64'(out_valid), 64'd0);
        chk("end_count", 64'(fetch_count), 64'd15);

        redirect_valid = 1'b1; redirect_target = 64'h0;
        step();
        chk("res_halted", 64'(halted), 64'd0);
        redirect_valid = 1'b0;
        step();
        chk("res_instr", 64'(out_instr), 64'h00a00f93);

        redirect_valid = 1'b1; redirect_target = 64'h22;
        step();
        chk("mis_fault", 64'(misalign_fault), 64'd1);
        chk("mis_valid", 64'(out_valid), 64'd0);
        redirect_target = 64'h0;
        step();
        chk("mis_sticky", 64'(misalign_fault), 64'd1);
        chk("mis_addr", imem_addr, 64'h4);
        redirect_valid = 1'b0; reset = 1'b0;
        step();
        chk("mis_clear", 64'(misalign_fault), 64'd0);
        reset = 1'b1;
        step();
        chk("mis_restart_pc", out_pc, 64'h0);
        chk("mis_restart_vld", 64'(out_valid), 64'd1);

        redirect_valid = 1'b1; redirect_target = 64'hffff_ffff_ffff_fffc;
        step();
        redirect_valid = 1'b0;
        step();
        chk("ovf_halted", 64'(halted), 64'd1);
        chk("ovf_valid", 64'(out_valid), 64'd0);

        redirect_valid = 1'b1; redirect_target = 64'h48;
        step();
        redirect_valid = 1'b0;
        step();
        chk("last_pc", out_pc, 64'h48);
        step();
        chk("last_halted", 64'(halted), 64'd1);

        redirect_valid = 1'b1; redirect_target = 64'h0;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            stall = (i % 2 == 1);
            out_ready = (i != 2);
            step();
        end
        stall = 1'b1; reset = 1'b0;
        step();
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_pc", out_pc, 64'h0);
        chk("mrst_instr", 64'(out_instr), 64'd0);
        chk("mrst_count", 64'(fetch_count), 64'd0);
        chk("mrst_addr", imem_addr, 64'h0);
        reset = 1'b1; stall = 1'b0; out_ready = 1'b1;
        step();
        chk("mrst_first_pc", out_pc, 64'h0);
        chk("mrst_first_vld", 64'(out_valid), 64'd1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
